result_drain: RTL and testbench

// Reader side of the SystolicArray result interface. On a start pulse, waits a fixed

---
 rtl/result_drain.sv | 134 +++++++++++++
 tb/tb_result_drain.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/result_drain.sv
// result_drain: waits a fixed compute latency after start, snapshots the result
// matrix C, then streams it out row-major over a valid/ready handshake.
module result_drain #(
  parameter int WIDTH          = 8,
  parameter int SIZE           = 4,
  parameter int COMPUTE_CYCLES = 3 * SIZE
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic signed [2*WIDTH-1:0]   C [0:SIZE-1][0:SIZE-1],
  output logic signed [2*WIDTH-1:0]   out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_row_last,
  output logic                        out_last,
  output logic                        busy,
  output logic                        done
);

  localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int CW = (COMPUTE_CYCLES > 1) ? $clog2(COMPUTE_CYCLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(SIZE - 1);

  typedef enum logic [1:0] {IDLE, WAIT, STREAM} state_e;

  state_e                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [IW-1:0]             row_q, row_d;
  logic [IW-1:0]             col_q, col_d;
  logic [IW-1:0]             nrow, ncol;
  logic signed [2*WIDTH-1:0] buf_q [0:SIZE-1][0:SIZE-1];
  logic signed [2*WIDTH-1:0] buf_d [0:SIZE-1][0:SIZE-1];
  logic signed [2*WIDTH-1:0] data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      rlast_q, rlast_d;
  logic                      last_q, last_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    col_d   = col_q;
    buf_d   = buf_q;
    data_d  = data_q;
    valid_d = valid_q;
    rlast_d = rlast_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ncol    = (col_q == LAST_IDX) ? '0 : col_q + 1'b1;
    nrow    = (col_q == LAST_IDX) ? row_q + 1'b1 : row_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WAIT;
          cnt_d   = CW'(COMPUTE_CYCLES - 1);
          busy_d  = 1'b1;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          // First element comes straight from C; the buffer fills on this edge.
          buf_d   = C;
          row_d   = '0;
          col_d   = '0;
          data_d  = C[0][0];
          valid_d = 1'b1;
          rlast_d = (SIZE == 1);
          last_d  = (SIZE == 1);
          state_d = STREAM;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (last_q) begin
            state_d = IDLE;
            valid_d = 1'b0;
            rlast_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            row_d   = nrow;
            col_d   = ncol;
            data_d  = buf_q[nrow][ncol];
            rlast_d = (ncol == LAST_IDX);
            last_d  = (ncol == LAST_IDX) && (nrow == LAST_IDX);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    buf_q <= buf_d;
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      rlast_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      rlast_q <= rlast_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out_data     = data_q;
  assign out_valid    = valid_q;
  assign out_row_last = rlast_q;
  assign out_last     = last_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_result_drain.sv
// tb_result_drain: directed bench for result_drain with hand-derived
// expected streams, latency, backpressure, ignored starts and mid-stream reset.
module tb_result_drain;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic signed [15:0] c_in [0:3][0:3];
  logic signed [15:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic               out_row_last;
  logic               out_last;
  logic               busy;
  logic               done;

  logic signed [15:0] expv [16];
  int checks = 0;
  int fails  = 0;

  result_drain #(.WIDTH(8), .SIZE(4), .COMPUTE_CYCLES(12)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .C(c_in),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_row_last(out_row_last),
    .out_last(out_last),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_c(input int mode);
    logic signed [15:0] v;
    for (int i = 0; i < 16; i++) begin
      case (mode)
        0: v = 16'(i + 1);
        1: case (i % 4)
             0: v = -16'sd32768;
             1: v = -16'sd1;
             2: v = 16'sd32767;
             default: v = 16'(i * 1000);
           endcase
        default: v = 16'(i * 37 - 300);
      endcase
      c_in[i/4][i%4] = v;
      expv[i] = v;
    end
  endtask

  task automatic scramble_c();
    for (int i = 0; i < 16; i++) c_in[i/4][i%4] = 16'(16'h5a5a ^ i);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_rlast"}, out_row_last, 0);
    chk({tag, "_last"}, out_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // Call right after the start edge; rmode 1 applies ready 1,0,0 repeating.
  task automatic drain(input int rmode, input bit poke, input bit restart);
    int  waitc = 0;
    int  k = 0;
    int  cyc = 0;
    bit  xfer;
    while (!out_valid && waitc < 20) begin
      chk("wait_busy", busy, 1);
      start = poke && (waitc == 3);
      tick();
      waitc++;
    end
    start = 1'b0;
    chk("latency", waitc, 12);
    scramble_c();
    while (k < 16 && cyc < 200) begin
      chk("s_valid", out_valid, 1);
      chk("s_busy", busy, 1);
      chk("s_done", done, 0);
      chk("s_data", out_data, expv[k]);
      chk("s_rlast", out_row_last, (k % 4) == 3);
      chk("s_last", out_last, k == 15);
      out_ready = (rmode == 0) ? 1'b1 : ((cyc % 3) == 0);
      start = poke && (cyc == 2 || k == 15);
      xfer = out_ready;
      tick();
      cyc++;
      if (xfer) k++;
    end
    start = 1'b0;
    chk("xfer_count", k, 16);
    if (rmode == 0) chk("no_bubbles", cyc, 16);
    chk("end_done", done, 1);
    chk("end_valid", out_valid, 0);
    chk("end_busy", busy, 0);
    start = restart;
    tick();
    start = 1'b0;
    chk("done_pulse", done, 0);
    chk("post_busy", busy, restart);
    chk("post_valid", out_valid, 0);
  endtask

  initial begin
    int w;
    rst = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    load_c(0);
    tick();
    tick();
    chk_idle("reset");

    rst = 1'b1;
    tick();
    start = 1'b1;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_busy", busy, 1);
    chk("t1_valid", out_valid, 0);
    drain(0, 1'b0, 1'b0);

    load_c(1);
    start = 1'b1;
    tick();
    start = 1'b0;
    drain(1, 1'b0, 1'b0);

    load_c(2);
    start = 1'b1;
    tick();
    start = 1'b0;
    drain(1, 1'b1, 1'b1);
    load_c(0);
    drain(0, 1'b0, 1'b0);

    load_c(2);
    start = 1'b1;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    w = 0;
    while (!out_valid && w < 20) begin
      tick();
      w++;
    end
    chk("r_latency", w, 12);
    for (int i = 0; i < 5; i++) tick();
    chk("r_data5", out_data, expv[5]);
    rst = 1'b0;
    tick();
    chk_idle("midrst");
    rst = 1'b1;
    tick();
    chk("r_idle_valid", out_valid, 0);
    chk("r_idle_busy", busy, 0);
    load_c(1);
    start = 1'b1;
    tick();
    start = 1'b0;
    drain(0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
